layer_sequencer: RTL and testbench

//  Time-multiplexes one serial signed MAC over a full dense layer: N_OUT neurons x N_IN inputs.
//  Per neuron: fetch bias, inputs and weights from synchronous-read memories; accumulate;

---
 rtl/layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_layer_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Runs one serial signed MAC over a whole dense layer (N_OUT neurons x N_IN
//   inputs). For each neuron j: read bias j, stream N_IN input/weight pairs,
//   accumulate at full precision, saturate to RES bits, optionally ReLU, then
//   write the result to the output buffer at address j.
// Ports
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_start, i_abort      run request (IDLE only) / synchronous abort
//   o_busy, o_done        handshake; o_done is a one-cycle pulse at layer end
//   o_in_addr, i_in_data  layer input buffer (1-cycle read latency)
//   o_w_addr, i_w_data    weight ROM, address j*N_IN+k (1-cycle latency)
//   o_b_addr, i_b_data    bias ROM, address j (1-cycle latency)
//   o_out_we/addr/data    next-layer input buffer write port
module layer_sequencer #(
    parameter  int N_IN     = 16,
    parameter  int N_OUT    = 10,
    parameter  int RES      = 8,
    parameter  int ACT_RELU = 0,
    localparam int IAW      = $clog2(N_IN),
    localparam int WAW      = $clog2(N_IN * N_OUT),
    localparam int BAW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic           i_abort,
    output logic           o_busy,
    output logic           o_done,
    output logic [IAW-1:0] o_in_addr,
    input  logic [RES-1:0] i_in_data,
    output logic [WAW-1:0] o_w_addr,
    input  logic [RES-1:0] i_w_data,
    output logic [BAW-1:0] o_b_addr,
    input  logic [RES-1:0] i_b_data,
    output logic           o_out_we,
    output logic [BAW-1:0] o_out_addr,
    output logic [RES-1:0] o_out_data
);
    localparam int KW   = $clog2(N_IN + 1);
    localparam int ACCW = 2 * RES + $clog2(N_IN) + 1;

    // Saturation bounds expressed at accumulator width, and at output width.
    localparam logic signed [ACCW-1:0] ACC_MAX = {{(ACCW-RES+1){1'b0}}, {(RES-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {{(ACCW-RES+1){1'b1}}, {(RES-1){1'b0}}};
    localparam logic [RES-1:0]         OUT_MAX = {1'b0, {(RES-1){1'b1}}};
    localparam logic [RES-1:0]         OUT_MIN = {1'b1, {(RES-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [BAW-1:0]         r_j;
    logic [KW-1:0]          r_k;
    logic [WAW-1:0]         r_wbase;   // j*N_IN kept incrementally, avoids a multiplier
    logic signed [ACCW-1:0] r_acc;

    logic                   w_last;
    logic signed [2*RES-1:0] w_in_x, w_wt_x, w_prod;
    logic signed [ACCW-1:0] w_prod_x, w_bias_x;
    logic [RES-1:0]         w_sat, w_f;

    assign w_last = (r_j == BAW'(N_OUT - 1));

    // Operands widened to 2*RES first; the exact product always fits in 2*RES.
    assign w_in_x   = {{RES{i_in_data[RES-1]}}, i_in_data};
    assign w_wt_x   = {{RES{i_w_data[RES-1]}}, i_w_data};
    assign w_prod   = w_in_x * w_wt_x;
    assign w_prod_x = {{(ACCW-2*RES){w_prod[2*RES-1]}}, w_prod};
    assign w_bias_x = {{(ACCW-RES){i_b_data[RES-1]}}, i_b_data};

    always_comb begin
        if (r_acc > ACC_MAX)      w_sat = OUT_MAX;
        else if (r_acc < ACC_MIN) w_sat = OUT_MIN;
        else                      w_sat = r_acc[RES-1:0];
        w_f = ((ACT_RELU != 0) && w_sat[RES-1]) ? '0 : w_sat;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_addr   = '0;
        o_w_addr    = '0;
        o_b_addr    = '0;
        o_out_we    = 1'b0;
        o_out_addr  = '0;
        o_out_data  = '0;
        o_done      = 1'b0;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                o_b_addr    = r_j;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                // k=0..N_IN-1 issue reads; data lands one cycle later (k=1..N_IN)
                if (r_k < KW'(N_IN)) begin
                    o_in_addr = IAW'(r_k);
                    o_w_addr  = r_wbase + WAW'(r_k);
                end
                if (r_k == KW'(N_IN)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                o_out_we    = 1'b1;
                o_out_addr  = r_j;
                o_out_data  = w_f;
                w_state_nxt = w_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort beats everything, including a start in IDLE, and cancels the
        // write/done of the cycle it arrives in.
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            o_out_we    = 1'b0;
            o_done      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_j     <= '0;
            r_k     <= '0;
            r_wbase <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_j     <= '0;
                    r_wbase <= '0;
                end
                S_LOAD:  r_k <= '0;
                S_MAC: begin
                    r_k <= r_k + 1'b1;
                    if (r_k == '0) r_acc <= w_bias_x;
                    else           r_acc <= r_acc + w_prod_x;
                end
                S_WRITE: begin
                    if (!w_last) begin
                        r_j     <= r_j + 1'b1;
                        r_wbase <= r_wbase + WAW'(N_IN);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
    localparam int N_IN = 4, N_OUT = 2, RES = 8;
    localparam int RUN_LEN = N_OUT * (N_IN + 3);   // done cycle

    logic clk = 1'b0;
    logic rst_n, start, abort;
    always #5 clk = ~clk;

    logic       busy0, done0, we0, busy1, done1, we1;
    logic [1:0] ia0, ia1;
    logic [2:0] wa0, wa1;
    logic [0:0] ba0, ba1, oa0, oa1;
    logic [7:0] od0, od1, iq0, wq0, bq0, iq1, wq1, bq1;

    logic [7:0] in_mem [4];
    logic [7:0] w_mem  [8];
    logic [7:0] b_mem  [2];

    always @(posedge clk) begin
        iq0 <= in_mem[ia0]; wq0 <= w_mem[wa0]; bq0 <= b_mem[ba0];
        iq1 <= in_mem[ia1]; wq1 <= w_mem[wa1]; bq1 <= b_mem[ba1];
    end

    layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .RES(RES), .ACT_RELU(0)) u_dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
        .o_busy(busy0), .o_done(done0),
        .o_in_addr(ia0), .i_in_data(iq0), .o_w_addr(wa0), .i_w_data(wq0),
        .o_b_addr(ba0), .i_b_data(bq0),
        .o_out_we(we0), .o_out_addr(oa0), .o_out_data(od0));

    layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .RES(RES), .ACT_RELU(1)) u_relu (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
        .o_busy(busy1), .o_done(done1),
        .o_in_addr(ia1), .i_in_data(iq1), .o_w_addr(wa1), .i_w_data(wq1),
        .o_b_addr(ba1), .i_b_data(bq1),
        .o_out_we(we1), .o_out_addr(oa1), .o_out_data(od1));

    int checks = 0, errors = 0;

    // per-cycle logs of the ACT_RELU=0 instance, indexed by cycle after start
    logic       busy_log [40];
    logic       we_log   [40];
    logic [2:0] wa_log   [40];
    logic [1:0] ia_log   [40];
    logic [0:0] ba_log   [40];
    logic [7:0] od_log   [40];
    logic [7:0] out0 [2];
    logic [7:0] out1 [2];
    int nwr0, nwr1, ndone, done_at;

    task automatic set_mem(input logic [7:0] iv, input logic [7:0] wv, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < 4; i++) in_mem[i] = iv;
        for (int i = 0; i < 8; i++) w_mem[i] = wv;
        b_mem[0] = b0; b_mem[1] = b1;
    endtask

    // Issue start, then run n cycles logging outputs at each negedge.
    // hold: keep (pulsing) start high through the run; ab_c: abort cycle;
    // rlo/rhi: cycles where reset goes low / high again (-1 = unused).
    task automatic run(input int n, input bit hold, input int ab_c, input int rlo, input int rhi);
        nwr0 = 0; nwr1 = 0; ndone = 0; done_at = -1;
        out0[0] = 8'h5A; out0[1] = 8'h5A; out1[0] = 8'h5A; out1[1] = 8'h5A;
        @(posedge clk); #1 start = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            start = hold && (c <= RUN_LEN) && ((c % 4) != 2);
            abort = (c == ab_c);
            if (c == rlo) rst_n = 1'b0;
            if (c == rhi) rst_n = 1'b1;
            @(negedge clk);
            busy_log[c] = busy0; we_log[c] = we0; wa_log[c] = wa0;
            ia_log[c] = ia0; ba_log[c] = ba0; od_log[c] = od0;
            if (we0) begin out0[oa0] = od0; nwr0++; end
            if (we1) begin out1[oa1] = od1; nwr1++; end
            if (done0) begin ndone++; done_at = c; end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        set_mem(8'd0, 8'd0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        checks++; if ({busy0, done0, we0} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy0, done0, we0}); end
        checks++; if ({ia0, wa0, ba0, oa0} !== 7'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", {ia0, wa0, ba0, oa0}); end
        checks++; if (od0 !== 8'd0) begin errors++; $display("FAIL reset_data: got %h want 00", od0); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b want 0", busy0); end
    endtask

    task automatic test_basic;
        set_mem(8'd1, 8'd2, 8'd3, 8'hFD);
        run(RUN_LEN + 2, 1'b0, -1, -1, -1);
        checks++; if (out0[0] !== 8'd11) begin errors++; $display("FAIL basic_out0: got %h want 0b", out0[0]); end
        checks++; if (out0[1] !== 8'd5) begin errors++; $display("FAIL basic_out1: got %h want 05", out0[1]); end
        checks++; if (out1[0] !== 8'd11 || out1[1] !== 8'd5) begin errors++; $display("FAIL basic_relu: got %h %h want 0b 05", out1[0], out1[1]); end
        checks++; if (nwr0 !== 2) begin errors++; $display("FAIL basic_nwr: got %0d want 2", nwr0); end
        checks++; if (ndone !== 1 || done_at !== RUN_LEN) begin errors++; $display("FAIL basic_done: got %0d pulses at %0d want 1 at %0d", ndone, done_at, RUN_LEN); end
        checks++; if (we_log[6] !== 1'b1 || we_log[13] !== 1'b1) begin errors++; $display("FAIL basic_wr_cyc: got %b%b want 11", we_log[6], we_log[13]); end
        checks++; if (ba_log[7] !== 1'b1) begin errors++; $display("FAIL basic_baddr: got %0d want 1", ba_log[7]); end
        checks++; if (busy_log[RUN_LEN] !== 1'b1 || busy_log[RUN_LEN+1] !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b%b want 10", busy_log[RUN_LEN], busy_log[RUN_LEN+1]); end
    endtask

    task automatic test_saturation;
        set_mem(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        run(RUN_LEN + 2, 1'b0, -1, -1, -1);
        checks++; if (out0[0] !== 8'h7F || out0[1] !== 8'h7F) begin errors++; $display("FAIL sat_pos: got %h %h want 7f 7f", out0[0], out0[1]); end
        set_mem(8'h7F, 8'h80, 8'h7F, 8'h7F);
        run(RUN_LEN + 2, 1'b0, -1, -1, -1);
        checks++; if (out0[0] !== 8'h80 || out0[1] !== 8'h80) begin errors++; $display("FAIL sat_neg: got %h %h want 80 80", out0[0], out0[1]); end
        checks++; if (out1[0] !== 8'h00 || out1[1] !== 8'h00) begin errors++; $display("FAIL sat_neg_relu: got %h %h want 00 00", out1[0], out1[1]); end
    endtask

    task automatic test_relu;
        set_mem(8'd0, 8'd7, 8'hFB, 8'd5);
        run(RUN_LEN + 2, 1'b0, -1, -1, -1);
        checks++; if (out0[0] !== 8'hFB || out0[1] !== 8'd5) begin errors++; $display("FAIL relu_off: got %h %h want fb 05", out0[0], out0[1]); end
        checks++; if (out1[0] !== 8'h00 || out1[1] !== 8'd5) begin errors++; $display("FAIL relu_on: got %h %h want 00 05", out1[0], out1[1]); end
    endtask

    task automatic test_mixed;
        // n0 = 1*1 + 2*-1 + 3*2 + 4*-2 = -3 ; n1 = 10 + 3*(1+2+3+4) = 40
        for (int i = 0; i < 4; i++) in_mem[i] = 8'(i + 1);
        w_mem[0] = 8'd1; w_mem[1] = 8'hFF; w_mem[2] = 8'd2; w_mem[3] = 8'hFE;
        for (int i = 4; i < 8; i++) w_mem[i] = 8'd3;
        b_mem[0] = 8'd0; b_mem[1] = 8'd10;
        run(RUN_LEN + 2, 1'b0, -1, -1, -1);
        checks++; if (out0[0] !== 8'hFD || out0[1] !== 8'd40) begin errors++; $display("FAIL mixed: got %h %h want fd 28", out0[0], out0[1]); end
        checks++; if (out1[0] !== 8'h00 || out1[1] !== 8'd40) begin errors++; $display("FAIL mixed_relu: got %h %h want 00 28", out1[0], out1[1]); end
    endtask

    task automatic test_start_held;
        set_mem(8'd1, 8'd2, 8'd3, 8'hFD);
        run(RUN_LEN + 4, 1'b1, -1, -1, -1);
        checks++; if (nwr0 !== 2 || ndone !== 1) begin errors++; $display("FAIL held_once: got %0d writes %0d done want 2 1", nwr0, ndone); end
        checks++; if (busy_log[RUN_LEN+1] !== 1'b0 || busy_log[RUN_LEN+3] !== 1'b0) begin errors++; $display("FAIL held_idle: got busy %b%b want 00", busy_log[RUN_LEN+1], busy_log[RUN_LEN+3]); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (wa_log[1+k] !== 3'(k) || ia_log[1+k] !== 2'(k)) begin errors++; $display("FAIL held_addr_n0[%0d]: got w=%0d i=%0d want %0d", k, wa_log[1+k], ia_log[1+k], k); end
            checks++; if (wa_log[8+k] !== 3'(4 + k)) begin errors++; $display("FAIL held_addr_n1[%0d]: got %0d want %0d", k, wa_log[8+k], 4 + k); end
        end
        checks++; if (wa_log[5] !== 3'd0 || wa_log[6] !== 3'd0) begin errors++; $display("FAIL held_addr_idle: got %0d %0d want 0 0", wa_log[5], wa_log[6]); end
    endtask

    task automatic test_abort;
        set_mem(8'd1, 8'd2, 8'd3, 8'hFD);
        run(RUN_LEN + 2, 1'b0, 9, -1, -1);
        checks++; if (busy_log[9] !== 1'b1 || busy_log[10] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b%b want 10", busy_log[9], busy_log[10]); end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", ndone); end
        checks++; if (nwr0 !== 1 || out0[0] !== 8'd11 || out0[1] !== 8'h5A) begin errors++; $display("FAIL abort_writes: got %0d writes %h %h want 1 0b 5a", nwr0, out0[0], out0[1]); end
        run(RUN_LEN + 2, 1'b0, -1, -1, -1);
        checks++; if (out0[0] !== 8'd11 || out0[1] !== 8'd5 || ndone !== 1) begin errors++; $display("FAIL abort_rerun: got %h %h done %0d want 0b 05 1", out0[0], out0[1], ndone); end
    endtask

    task automatic test_reset_midrun;
        set_mem(8'd1, 8'd2, 8'd3, 8'hFD);
        run(12, 1'b0, -1, 5, 7);
        checks++; if (busy_log[4] !== 1'b1 || busy_log[5] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b%b want 10", busy_log[4], busy_log[5]); end
        checks++; if (we_log[5] !== 1'b0 || wa_log[5] !== 3'd0 || ia_log[5] !== 2'd0 || od_log[5] !== 8'd0) begin errors++; $display("FAIL rst_mid_outs: got we=%b w=%0d i=%0d d=%h want 0", we_log[5], wa_log[5], ia_log[5], od_log[5]); end
        checks++; if (nwr0 !== 0 || ndone !== 0) begin errors++; $display("FAIL rst_mid_nowrite: got %0d writes %0d done want 0 0", nwr0, ndone); end
        run(RUN_LEN + 2, 1'b0, -1, -1, -1);
        checks++; if (out0[0] !== 8'd11 || out0[1] !== 8'd5 || ndone !== 1) begin errors++; $display("FAIL rst_mid_rerun: got %h %h done %0d want 0b 05 1", out0[0], out0[1], ndone); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_mixed();
        test_start_held();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
